// File: rtl/alu64bit_seq_if.sv
// ============================================================================
//  Module   : alu64bit_seq_if
//  Brief    : Request/result handshake bundle for the alu64bit sequencer
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface alu64bit_seq_if #(
    parameter int W = 64
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic [1:0]   in_op;
    logic         in_acc;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_s;
    logic         out_cout;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_op, in_acc, out_ready,
        input  in_ready, out_valid, out_s, out_cout
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_op, in_acc, out_ready,
        output in_ready, out_valid, out_s, out_cout
    );
endinterface

`default_nettype wire

// File: rtl/alu64bit_seq.sv
// ============================================================================
//  Module   : alu64bit_seq
//  Brief    : Sequencer that holds operands on an external ripple-carry ALU,
//             captures its settled result and keeps a chaining accumulator
//  Revision : 1.0
// ============================================================================
`default_nettype none

module alu64bit_seq #(
    parameter int W             = 64,
    parameter int SETTLE_CYCLES = 4
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    alu64bit_seq_if.slave     bus,
    output logic [W-1:0]      alu_a,
    output logic [W-1:0]      alu_b,
    output logic              alu_cin,
    output logic [1:0]        alu_op,
    input  wire logic [W-1:0] alu_s,
    input  wire logic         alu_cout
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;

    // Counter loads SETTLE_CYCLES-1 so capture lands exactly SETTLE_CYCLES edges after accept
    localparam logic [7:0] C_CNT_LOAD = 8'(SETTLE_CYCLES - 1);

    logic [1:0]   state_q, state_d;
    logic [7:0]   cnt_q,   cnt_d;
    logic [W-1:0] acc_q,   acc_d;
    logic [W-1:0] res_q,   res_d;
    logic         cout_q,  cout_d;
    logic [W-1:0] alu_a_q, alu_a_d;
    logic [W-1:0] alu_b_q, alu_b_d;
    logic         alu_cin_q, alu_cin_d;
    logic [1:0]   alu_op_q,  alu_op_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        res_d     = res_q;
        cout_d    = cout_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_cin_d = alu_cin_q;
        alu_op_d  = alu_op_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    alu_a_d   = bus.in_acc ? acc_q : bus.in_a;
                    alu_b_d   = bus.in_b;
                    alu_cin_d = bus.in_cin;
                    alu_op_d  = bus.in_op;
                    cnt_d     = C_CNT_LOAD;
                    state_d   = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == 8'd0) begin
                    res_d   = alu_s;
                    cout_d  = alu_cout;
                    acc_d   = alu_s;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            acc_q     <= '0;
            res_q     <= '0;
            cout_q    <= 1'b0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_cin_q <= 1'b0;
            alu_op_q  <= 2'b00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            res_q     <= res_d;
            cout_q    <= cout_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_cin_q <= alu_cin_d;
            alu_op_q  <= alu_op_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_HOLD);
    assign bus.out_s     = res_q;
    assign bus.out_cout  = cout_q;

    assign alu_a   = alu_a_q;
    assign alu_b   = alu_b_q;
    assign alu_cin = alu_cin_q;
    assign alu_op  = alu_op_q;

endmodule

`default_nettype wire

// File: tb/tb_alu64bit_seq.sv
// ============================================================================
//  Module   : tb_alu64bit_seq
//  Brief    : Directed bench for alu64bit_seq with a behavioural alu64bit
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu64bit_seq;

    localparam int W             = 64;
    localparam int SETTLE_CYCLES = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] alu_a, alu_b, alu_s;
    logic         alu_cin, alu_cout;
    logic [1:0]   alu_op;

    int n_chk;
    int n_bad;

    alu64bit_seq_if #(.W(W)) bus ();

    alu64bit_seq #(.W(W), .SETTLE_CYCLES(SETTLE_CYCLES)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_cin  (alu_cin),
        .alu_op   (alu_op),
        .alu_s    (alu_s),
        .alu_cout (alu_cout)
    );

    // Stand-in for the combinational alu64bit
    always_comb begin
        logic [W:0] w_sum;
        w_sum    = '0;
        alu_s    = '0;
        alu_cout = 1'b0;
        case (alu_op)
            2'b00: alu_s = ~(alu_a | alu_b);
            2'b01: alu_s = alu_a ^ alu_b;
            2'b10: begin
                w_sum    = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_cin};
                alu_s    = w_sum[W-1:0];
                alu_cout = w_sum[W];
            end
            default: begin
                w_sum    = {1'b0, alu_a} + {1'b0, ~alu_b} + {{W{1'b0}}, 1'b1};
                alu_s    = w_sum[W-1:0];
                alu_cout = w_sum[W];
            end
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, wait for the result, consume it; reports latency in edges after accept
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic [1:0] op, input logic acc,
                          output logic [W-1:0] s, output logic cout, output int lat);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            tick();
            guard++;
        end
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        bus.in_op    = op;
        bus.in_acc   = acc;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            tick();
            lat++;
        end
        if (!bus.out_valid) begin
            chk("timeout", 64'd0, 64'd1);
        end
        s    = bus.out_s;
        cout = bus.out_cout;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    localparam logic [W-1:0] C_A = 64'h7DFB_FFBF_7FFF_BF7D;
    localparam logic [W-1:0] C_B = 64'h4303_CFEF_2061_F1C3;

    initial begin
        logic [W-1:0] s;
        logic [W-1:0] s_held;
        logic         c;
        int           lat;

        n_chk = 0;
        n_bad = 0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.in_op     = 2'b00;
        bus.in_acc    = 1'b0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        tick();
        tick();

        chk("rst_in_ready",  {63'd0, bus.in_ready},  64'd1);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_out_s",     bus.out_s,              64'd0);
        chk("rst_alu_a",     alu_a,                  64'd0);
        rst_n = 1'b1;
        tick();

        // ADD wrap-around with carry out
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 2'b10, 1'b0, s, c, lat);
        chk("wrap_s",    s,               64'd0);
        chk("wrap_cout", {63'd0, c},      64'd1);
        chk("wrap_lat",  64'(lat),        64'(SETTLE_CYCLES));

        run_op(C_A, C_B, 1'b0, 2'b10, 1'b0, s, c, lat);
        chk("add_mixed", s, 64'hC0FF_CFAE_A061_B140);
        run_op(C_A, C_B, 1'b0, 2'b11, 1'b0, s, c, lat);
        chk("sub_mixed", s, 64'h3AF8_2FD0_5F9D_CDBA);
        run_op(C_A, C_B, 1'b0, 2'b00, 1'b0, s, c, lat);
        chk("nor_mixed", s, 64'h8004_0000_8000_0000);
        run_op(C_A, C_B, 1'b0, 2'b01, 1'b0, s, c, lat);
        chk("xor_mixed", s, 64'h3EF8_3050_5F9E_4EBE);

        // Backpressure: result held for 10 cycles while a new request waits
        bus.in_a = 64'd10; bus.in_b = 64'd20; bus.in_cin = 1'b0;
        bus.in_op = 2'b10; bus.in_acc = 1'b0; bus.in_valid = 1'b1;
        tick();
        bus.in_a = 64'd999;
        for (int i = 0; i < SETTLE_CYCLES; i++) tick();
        chk("bp_valid0", {63'd0, bus.out_valid}, 64'd1);
        s_held = bus.out_s;
        chk("bp_result", s_held, 64'd30);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_valid",   {63'd0, bus.out_valid}, 64'd1);
            chk("bp_stable",  bus.out_s,              64'd30);
            chk("bp_inready", {63'd0, bus.in_ready},  64'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("bp_release_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("bp_release_ready", {63'd0, bus.in_ready},  64'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("bp_accepted", {63'd0, bus.in_ready}, 64'd0);
        chk("bp_new_a",    alu_a,                 64'd999);
        for (int i = 0; i < SETTLE_CYCLES; i++) tick();
        chk("bp_new_s", bus.out_s, 64'd1019);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Accumulator chaining; in_a must be ignored on the second op
        run_op(64'd5, 64'd3, 1'b0, 2'b10, 1'b0, s, c, lat);
        chk("acc_first", s, 64'd8);
        run_op(64'hDEAD_BEEF_0000_0001, 64'd2, 1'b0, 2'b11, 1'b1, s, c, lat);
        chk("acc_second", s, 64'd6);

        // Reset in the middle of SETTLE discards the operation
        bus.in_a = 64'd7; bus.in_b = 64'd9; bus.in_op = 2'b10; bus.in_acc = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #2;
        chk("mid_rst_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("mid_rst_ready", {63'd0, bus.in_ready},  64'd1);
        chk("mid_rst_s",     bus.out_s,              64'd0);
        chk("mid_rst_cout",  {63'd0, bus.out_cout},  64'd0);
        chk("mid_rst_alu",   {alu_a ^ alu_b, 62'd0} | {62'd0, alu_op} | {63'd0, alu_cin}, 64'd0);
        chk("mid_rst_alu_a", alu_a, 64'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < SETTLE_CYCLES + 3; i++) begin
            tick();
            chk("post_rst_valid", {63'd0, bus.out_valid}, 64'd0);
        end
        run_op(64'd1, 64'd1, 1'b0, 2'b10, 1'b0, s, c, lat);
        chk("post_rst_add", s, 64'd2);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
